// File: rtl/window_stream_buffer.sv
// window_stream_buffer: raster-order pixel stream in, one 3x3 window per
// image pixel out, centred on that pixel, with zero or clamped borders.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a beat carrying inSof; other beats are discarded
//   FILL  | storing the first IMG_W+1 pixels; no windows yet
//   RUN   | each accepted pixel emits the window lagging it by IMG_W+1
//   FLUSH | input held off; IMG_W+1 self-timed beats drain the last windows
//
// Datapath: two line memories (rows y-2 and y-1 at the input column) feed a
// new column each beat. Two column registers hold the previous two columns.
// The window for the current centre is {older col, newer col, new col}, with
// border taps replaced according to the centre position. The centre lags
// the input by one row plus one column, so when the input is at column 0 the
// centre sits on the last column of the previous centre row and the new
// column is never used (it is always the padded right column).
module window_stream_buffer #(
  parameter int PIX_W     = 12,
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int EDGE_MODE = 0
) (
  input  logic               vgaClk,
  input  logic               resetN,
  input  logic               inValid,
  output logic               inReady,
  input  logic               inSof,
  input  logic [PIX_W-1:0]   inPixel,
  output logic               outValid,
  output logic [9*PIX_W-1:0] outWindow,
  output logic [9:0]         outX,
  output logic [8:0]         outY,
  output logic               outSof,
  output logic               outEof,
  output logic               frameErr
);

  localparam int AW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t          state;
  logic [AW-1:0]   in_x;
  logic [YW-1:0]   in_y;
  logic [AW-1:0]   cen_x;
  logic [YW-1:0]   cen_y;
  logic [FW-1:0]   flush_cnt;

  logic [PIX_W-1:0] mem1 [IMG_W];
  logic [PIX_W-1:0] mem2 [IMG_W];

  logic [2:0][PIX_W-1:0]      col_a;
  logic [2:0][PIX_W-1:0]      col_b;
  logic [2:0][PIX_W-1:0]      col_new;
  logic [2:0][2:0][PIX_W-1:0] win;

  logic             acc;
  logic             start;
  logic             run_beat;
  logic             flush_beat;
  logic             beat;
  logic             fill_done;
  logic             last_in;
  logic             emit;
  logic             in_last_x;
  logic             cen_last_x;
  logic             cen_last_y;
  logic [AW-1:0]    addr;
  logic [PIX_W-1:0] new_pix;

  assign acc        = inValid && inReady;
  assign start      = acc && inSof;
  assign run_beat   = acc && !inSof && (state == FILL || state == RUN);
  assign flush_beat = (state == FLUSH);
  assign beat       = start || run_beat || flush_beat;
  assign in_last_x  = (in_x == AW'(IMG_W - 1));
  assign fill_done  = (in_x == AW'(1)) && (in_y == YW'(1));
  assign last_in    = in_last_x && (in_y == YW'(IMG_H - 1));
  assign emit       = (run_beat && (state == RUN || fill_done)) || flush_beat;
  assign cen_last_x = (cen_x == AW'(IMG_W - 1));
  assign cen_last_y = (cen_y == YW'(IMG_H - 1));
  assign addr       = start ? '0 : in_x;
  // Flush beats have no real bottom row; those taps are always padded.
  assign new_pix    = flush_beat ? '0 : inPixel;
  assign col_new    = {new_pix, mem1[addr], mem2[addr]};

  // Line memories (read-before-write at one address) and the column shift.
  always_ff @(posedge vgaClk) begin
    if (resetN && beat) begin
      mem1[addr] <= new_pix;
      mem2[addr] <= mem1[addr];
      col_a      <= col_b;
      col_b      <= col_new;
    end
  end

  // Assemble the window for the current centre and apply border handling.
  always_comb begin
    logic [2:0][2:0][PIX_W-1:0] w;
    w[0] = col_a;
    w[1] = col_b;
    w[2] = col_new;
    for (int c = 0; c < 3; c++) begin
      if (cen_y == '0)
        w[c][0] = (EDGE_MODE != 0) ? w[c][1] : '0;
      if (cen_last_y)
        w[c][2] = (EDGE_MODE != 0) ? w[c][1] : '0;
    end
    // Column substitution after row fixing so corners clamp to the centre.
    if (cen_x == '0)
      w[0] = (EDGE_MODE != 0) ? w[1] : '0;
    if (cen_last_x)
      w[2] = (EDGE_MODE != 0) ? w[1] : '0;
    win = w;
  end

  // Sequencing FSM with registered handshake and window outputs.
  always_ff @(posedge vgaClk) begin
    if (!resetN) begin
      state     <= IDLE;
      inReady   <= 1'b1;
      outValid  <= 1'b0;
      outWindow <= '0;
      outX      <= '0;
      outY      <= '0;
      outSof    <= 1'b0;
      outEof    <= 1'b0;
      frameErr  <= 1'b0;
      in_x      <= '0;
      in_y      <= '0;
      cen_x     <= '0;
      cen_y     <= '0;
      flush_cnt <= '0;
    end else begin
      outValid <= emit;
      outSof   <= 1'b0;
      outEof   <= 1'b0;
      frameErr <= start && (state == FILL || state == RUN);

      if (emit) begin
        outWindow <= win;
        outX      <= 10'(cen_x);
        outY      <= 9'(cen_y);
        outSof    <= (cen_x == '0) && (cen_y == '0);
        outEof    <= cen_last_x && cen_last_y;
        if (cen_last_x) begin
          cen_x <= '0;
          cen_y <= cen_last_y ? '0 : cen_y + YW'(1);
        end else begin
          cen_x <= cen_x + AW'(1);
        end
      end

      if (start) begin
        state <= FILL;
        in_x  <= AW'(1);
        in_y  <= '0;
        cen_x <= '0;
        cen_y <= '0;
      end else if (run_beat) begin
        if (in_last_x) begin
          in_x <= '0;
          in_y <= (in_y == YW'(IMG_H - 1)) ? '0 : in_y + YW'(1);
        end else begin
          in_x <= in_x + AW'(1);
        end
        if (state == FILL && fill_done)
          state <= RUN;
        if (state == RUN && last_in) begin
          state     <= FLUSH;
          inReady   <= 1'b0;
          flush_cnt <= FW'(IMG_W);
        end
      end else if (flush_beat) begin
        in_x <= in_last_x ? '0 : in_x + AW'(1);
        if (flush_cnt == '0) begin
          state   <= IDLE;
          inReady <= 1'b1;
        end else begin
          flush_cnt <= flush_cnt - FW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_window_stream_buffer.sv
// Bench for window_stream_buffer: two instances (zero pad and clamp) share
// one 4x3 stimulus stream; expected windows are queued as pixels are
// accepted and compared as each window appears.
module tb_window_stream_buffer;

  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid;
  logic          in_sof;
  logic [PW-1:0] in_pixel;

  logic          rdy0, ov0, sof0, eof0, ferr0;
  logic [71:0]   win0;
  logic [9:0]    x0;
  logic [8:0]    y0;
  logic          rdy1, ov1, sof1, eof1, ferr1;
  logic [71:0]   win1;
  logic [9:0]    x1;
  logic [8:0]    y1;

  window_stream_buffer #(.PIX_W(PW), .IMG_W(W), .IMG_H(H), .EDGE_MODE(0)) dut0 (
    .vgaClk(clk), .resetN(rst_n), .inValid(in_valid), .inReady(rdy0),
    .inSof(in_sof), .inPixel(in_pixel), .outValid(ov0), .outWindow(win0),
    .outX(x0), .outY(y0), .outSof(sof0), .outEof(eof0), .frameErr(ferr0)
  );

  window_stream_buffer #(.PIX_W(PW), .IMG_W(W), .IMG_H(H), .EDGE_MODE(1)) dut1 (
    .vgaClk(clk), .resetN(rst_n), .inValid(in_valid), .inReady(rdy1),
    .inSof(in_sof), .inPixel(in_pixel), .outValid(ov1), .outWindow(win1),
    .outX(x1), .outY(y1), .outSof(sof1), .outEof(eof1), .frameErr(ferr1)
  );

  typedef struct packed {
    logic [71:0] w0;
    logic [71:0] w1;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        sof;
    logic        eof;
  } exp_t;

  typedef struct packed {
    logic [1:0]      mode;
    logic [3:0]      cx;
    logic [3:0]      cy;
    logic            eof;
    logic [0:8][7:0] taps;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  int n_cmp = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  int eof_cnt = 0;
  int ferr_cnt0 = 0;
  int ferr_cnt1 = 0;
  bit prev_acc = 1'b0;
  bit prev_rdy = 1'b1;

  logic [71:0] cap_w [2][W*H];
  logic        cap_e [2][W*H];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] tap(input int x, input int y, input int mode);
    int xx, yy;
    xx = x;
    yy = y;
    if (mode == 1) begin
      if (xx < 0) xx = 0;
      if (xx > W - 1) xx = W - 1;
      if (yy < 0) yy = 0;
      if (yy > H - 1) yy = H - 1;
    end else if (xx < 0 || xx >= W || yy < 0 || yy >= H) begin
      return 8'd0;
    end
    return 8'(16 * yy + xx + 1);
  endfunction

  function automatic exp_t make_exp(input int cx, input int cy);
    exp_t e;
    e.w0 = '0;
    e.w1 = '0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++) begin
        e.w0[(c*3+r)*8 +: 8] = tap(cx + c - 1, cy + r - 1, 0);
        e.w1[(c*3+r)*8 +: 8] = tap(cx + c - 1, cy + r - 1, 1);
      end
    e.x   = 10'(cx);
    e.y   = 9'(cy);
    e.sof = (cx == 0 && cy == 0);
    e.eof = (cx == W - 1 && cy == H - 1);
    return e;
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (ferr0) ferr_cnt0++;
    if (ferr1) ferr_cnt1++;
    if (ov0 || ov1) begin
      valid_cnt++;
      check("valid_both", 128'({ov0, ov1}), 128'(2'b11));
      check("valid_after_accept_or_flush", 128'(prev_acc || !prev_rdy), 128'(1'b1));
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_window: got outValid with x=%0d y=%0d, required no window", x0, y0);
      end else begin
        e = sb.pop_front();
        check($sformatf("win_m0_%0d_%0d", e.x, e.y), 128'({win0, x0, y0, sof0, eof0}),
              128'({e.w0, e.x, e.y, e.sof, e.eof}));
        check($sformatf("win_m1_%0d_%0d", e.x, e.y), 128'({win1, x1, y1, sof1, eof1}),
              128'({e.w1, e.x, e.y, e.sof, e.eof}));
        cap_w[0][int'(e.y) * W + int'(e.x)] = win0;
        cap_w[1][int'(e.y) * W + int'(e.x)] = win1;
        cap_e[0][int'(e.y) * W + int'(e.x)] = eof0;
        cap_e[1][int'(e.y) * W + int'(e.x)] = eof1;
        if (eof0) eof_cnt++;
      end
    end
    prev_acc = in_valid && rdy0;
    prev_rdy = rdy0;
  end

  task automatic send(input logic [7:0] pix, input logic sof);
    int budget;
    bit done;
    budget   = 0;
    done     = 1'b0;
    in_valid = 1'b1;
    in_pixel = pix;
    in_sof   = sof;
    while (!done) begin
      @(negedge clk);
      if (rdy0) done = 1'b1;
      @(posedge clk);
      #1;
      if (!done) begin
        budget++;
        if (budget > 40) begin
          n_cmp++;
          n_fail++;
          $display("FAIL send_timeout: inReady 0 for %0d cycles, required 1", budget);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic flush_check();
    for (int k = 0; k < W + 1; k++) begin
      @(negedge clk);
      check("flush_ready_low", 128'({rdy0, rdy1}), 128'(2'b00));
      check("flush_valid", 128'({ov0, ov1}), 128'(2'b11));
    end
    @(negedge clk);
    check("flush_end_ready_eof", 128'({rdy0, ov0, eof0, rdy1, ov1, eof1}), 128'(6'b111111));
  endtask

  task automatic run_frame(input int n_pix, input bit gaps, input bit push, input bit chk_flush);
    for (int i = 0; i < n_pix; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        while ($urandom_range(0, 1) == 1) begin
          @(posedge clk);
          #1;
        end
      end
      send(8'(16 * (i / W) + (i % W) + 1), (i == 0));
      if (push && i >= W + 1)
        sb.push_back(make_exp((i - W - 1) % W, (i - W - 1) / W));
      if (push && i == W * H - 1)
        for (int j = W * H - W - 1; j < W * H; j++)
          sb.push_back(make_exp(j % W, j / W));
    end
    if (chk_flush) fork flush_check(); join_none
  endtask

  task automatic drain();
    repeat (W + 4) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string name);
    check({name, "_m0"}, 128'({ov0, win0, x0, y0, sof0, eof0, ferr0}), 128'(0));
    check({name, "_m1"}, 128'({ov1, win1, x1, y1, sof1, eof1, ferr1}), 128'(0));
    check({name, "_ready"}, 128'({rdy0, rdy1}), 128'(2'b11));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required self-termination");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, idx, v_before;
    logic [71:0] req;

    vecs[0] = '{mode: 2'd0, cx: 4'd0, cy: 4'd0, eof: 1'b0,
                taps: {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd17, 8'd0, 8'd2, 8'd18}};
    vecs[1] = '{mode: 2'd1, cx: 4'd0, cy: 4'd0, eof: 1'b0,
                taps: {8'd1, 8'd1, 8'd17, 8'd1, 8'd1, 8'd17, 8'd2, 8'd2, 8'd18}};
    vecs[2] = '{mode: 2'd1, cx: 4'd3, cy: 4'd2, eof: 1'b1,
                taps: {8'd19, 8'd35, 8'd35, 8'd20, 8'd36, 8'd36, 8'd20, 8'd36, 8'd36}};
    vecs[3] = '{mode: 2'd0, cx: 4'd1, cy: 4'd1, eof: 1'b0,
                taps: {8'd1, 8'd17, 8'd33, 8'd2, 8'd18, 8'd34, 8'd3, 8'd19, 8'd35}};
    vecs[4] = '{mode: 2'd1, cx: 4'd1, cy: 4'd1, eof: 1'b0,
                taps: {8'd1, 8'd17, 8'd33, 8'd2, 8'd18, 8'd34, 8'd3, 8'd19, 8'd35}};
    vecs[5] = '{mode: 2'd0, cx: 4'd3, cy: 4'd2, eof: 1'b1,
                taps: {8'd19, 8'd35, 8'd0, 8'd20, 8'd36, 8'd0, 8'd0, 8'd0, 8'd0}};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_init");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back frames: flush timing, then a frame offered during flush.
    run_frame(W * H, 1'b0, 1'b1, 1'b1);
    run_frame(W * H, 1'b0, 1'b1, 1'b1);
    drain();

    for (int v = 0; v < 6; v++) begin
      m   = int'(vecs[v].mode);
      idx = int'(vecs[v].cy) * W + int'(vecs[v].cx);
      for (int k = 0; k < 9; k++) req[k*8 +: 8] = vecs[v].taps[k];
      check($sformatf("table_m%0d_x%0d_y%0d", m, vecs[v].cx, vecs[v].cy),
            128'({cap_w[m][idx], cap_e[m][idx]}), 128'({req, vecs[v].eof}));
    end

    // Random input gaps.
    run_frame(W * H, 1'b1, 1'b1, 1'b0);
    drain();

    // Resync on the 7th pixel, then a full frame.
    run_frame(6, 1'b0, 1'b1, 1'b0);
    run_frame(W * H, 1'b0, 1'b1, 1'b0);
    drain();
    check("frame_err_m0", 128'(ferr_cnt0), 128'(1));
    check("frame_err_m1", 128'(ferr_cnt1), 128'(1));
    check("eof_count", 128'(eof_cnt), 128'(4));

    // Reset during RUN, then pixels without inSof.
    run_frame(8, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset("reset_mid_run");
    rst_n = 1'b1;
    v_before = valid_cnt;
    for (int i = 0; i < 8; i++) send(8'(i + 100), 1'b0);
    drain();
    check("quiet_after_reset", 128'(valid_cnt - v_before), 128'(0));

    check("scoreboard_empty", 128'(sb.size()), 128'(0));
    check("window_total", 128'(valid_cnt), 128'(4 * W * H + 1 + 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/window_stream_buffer.md
Name: window_stream_buffer

Overview:
- Parametrised successor to the fixed 640x480 line/pixel buffering in the camera pipeline.
- Accepts a raster-order pixel stream and emits one 3x3 neighbourhood window per image pixel, centred on that pixel.
- Border pixels are zero-padded or replicated, selected by parameter.
- Sits between frame-buffer readout and the median, blur and edge stages.
- Adds a ready/valid input handshake, start-of-frame resync and an end-of-frame flush, none of which the current fixed buffers have.

Parameters:
PIX_W, 12, bits per pixel (packed channels, e.g. 4R/4G/4B)
IMG_W, 640, active pixels per line (≥3)
IMG_H, 480, active lines per frame (≥3)
EDGE_MODE, 0, 0 = out-of-image neighbours read 0; 1 = clamp to nearest in-image pixel

Ports:
vgaClk  in  1  single clock
resetN  in  1  synchronous active-low reset
inValid  in  1  input pixel valid
inReady  out  1  block can accept input
inSof  in  1  qualifies first pixel of a frame
inPixel  in  PIX_W  input pixel
outValid  out  1  window valid (no output backpressure)
outWindow  out  9*PIX_W  slice k = col*3+row; col l/m/r = x-1/x/x+1, row u/m/d = y-1/y/y+1; lu at [PIX_W-1:0], rd at top
outX  out  10  centre x
outY  out  9  centre y
outSof  out  1  high with window (0,0)
outEof  out  1  high with window (IMG_W-1, IMG_H-1)
frameErr  out  1  one-cycle pulse on a mid-frame inSof

Behaviour:
- Reset (resetN=0 at a vgaClk edge):
  - State goes to IDLE.
  - All outputs are 0 except inReady, which is 1.
  - Line-buffer contents are don't-care.
  - Reset mid-frame or mid-flush abandons the frame; no further outValid until a new inSof.
- Accept: a beat is accepted when inValid && inReady.
- FSM states: IDLE, FILL, RUN, FLUSH.
- IDLE:
  - Accepted beats without inSof are discarded.
  - An accepted beat with inSof is pixel (0,0); go to FILL.
- FILL:
  - Store pixels until index IMG_W+1, i.e. P(1,1), is accepted, then go to RUN.
  - No outValid in FILL.
- RUN:
  - Each accepted input with linear index i produces the window centred on index j = i-IMG_W-1.
  - outValid is registered and asserts on the cycle after acceptance; latency is 1 cycle from the acceptance edge.
  - When the last pixel (IMG_W*IMG_H-1) is accepted, go to FLUSH.
- FLUSH:
  - inReady=0.
  - The block self-generates exactly IMG_W+1 beats, one per cycle, each emitting the next window.
  - Missing below-row/right neighbours are resolved by EDGE_MODE.
  - After the final beat (the outEof window), go to IDLE.
- Flush overlap: inSof arriving during FLUSH is not accepted; it is held off by inReady.
- Windows per frame: exactly IMG_W*IMG_H, emitted in raster order of centre.
- Input stalls (inValid=0): no state change, no output.
- Padding:
  - For a centre on row 0, column 0, column IMG_W-1 or row IMG_H-1, out-of-range taps are 0 in mode 0.
  - In mode 1, out-of-range taps are clamp(x), clamp(y).
  - Pixels never wrap across lines or frames.
- Resync: inSof accepted while in FILL or RUN:
  - frameErr pulses.
  - The partial frame is dropped; no outEof for it.
  - That pixel becomes (0,0) of a new frame, in FILL.
- outSof/outEof are coincident with outValid only.
- outX/outY hold their last value when outValid=0.
- Storage:
  - Two line memories of IMG_W×PIX_W, single-port-per-cycle friendly: read and write the same address on the same cycle, read-before-write.
  - A 3x3 register window.
- Counters:
  - Input x/y counters wrap at IMG_W-1 / IMG_H-1.
  - Output centre counters are derived separately.

Test Plan:
All tests use PIX_W=8, IMG_W=4, IMG_H=3; pixel P(x,y)=16y+x+1, streamed back-to-back with inSof on the first pixel.
1. EDGE_MODE=0, full frame:
   - First outValid is on the cycle after P(1,1) is accepted: outSof=1, outX=0, outY=0.
   - Window lu,lm,ld,mu,mm,md,ru,rm,rd = 0,0,0,0,1,17,0,2,18.
   - Exactly 12 windows are emitted.
2. EDGE_MODE=1, same stream:
   - Window (0,0) = 1,1,17,1,1,17,2,2,18.
   - Window (3,2) = 19,35,35,20,36,36,20,36,36 with outEof=1.
   - Interior window (1,1) = 1,17,33,2,18,34,3,19,35 in both modes.
3. Flush timing:
   - After P(3,2) is accepted, inReady=0 for exactly 5 cycles with outValid=1 on each.
   - Then inReady=1 and the state is IDLE.
   - A second frame presented immediately yields identical outputs.
4. Random inValid gaps (~50% duty):
   - Window values are identical to test 1.
   - outValid only occurs on the cycle after an accepted beat, except during flush.
5. Resync: inSof reasserted on the 7th pixel:
   - frameErr pulses once and no outEof is emitted for the aborted frame.
   - The following full frame matches test 1.
6. Reset:
   - resetN=0 for one cycle during RUN: all outputs 0, inReady=1.
   - Subsequent pixels without inSof produce no outValid.
